// File: rtl/adc_stream_run_ctrl.sv
// Run/stop sequencer for the ADC-to-UDP streaming datapath (single clock domain).
// Optional packet-count auto-stop is compiled in with `define PKT_LIMIT_EN.
module adc_stream_run_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int FLUSH_CYCLES  = 8,
  parameter int PKT_CNT_W     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 run_req_in,
  input  logic                 beat_last_in,
  input  logic                 pkt_idle_in,
`ifdef PKT_LIMIT_EN
  input  logic [PKT_CNT_W-1:0] pkt_limit_in,
`endif
  output logic                 dp_enable_out,
  output logic                 dp_flush_out,
  output logic                 busy_out,
  output logic [PKT_CNT_W-1:0] pkt_count_out,
  output logic                 drain_timeout_out,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam int CNT_MAX_SD = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_SD > FLUSH_CYCLES) ? CNT_MAX_SD : FLUSH_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // One shared down-counter times ARM, DRAIN and FLUSH; it is loaded with N-1 on entry.
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [PKT_CNT_W-1:0] PKT_ONE     = PKT_CNT_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PKT_CNT_W-1:0] pkt_d, pkt_inc;
  logic                 timeout_d;
  logic                 start_ok;
  logic                 limit_hit;

  assign pkt_inc   = (&pkt_count_out) ? pkt_count_out : pkt_count_out + PKT_ONE;
  assign state_out = state_q;

`ifdef PKT_LIMIT_EN
  logic [PKT_CNT_W-1:0] limit_q, limit_d;
  logic                 low_seen_q, low_seen_d;

  // Edge-armed start: a run may only begin after the request has been seen low.
  assign start_ok  = run_req_in && low_seen_q;
  assign limit_hit = (limit_q != '0) && (pkt_inc == limit_q);

  always_comb begin
    limit_d    = limit_q;
    low_seen_d = low_seen_q;
    if (state_q == S_IDLE && start_ok) begin
      limit_d    = pkt_limit_in;
      low_seen_d = 1'b0;
    end else if (!run_req_in) begin
      low_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      limit_q    <= '0;
      low_seen_q <= 1'b0;
    end else begin
      limit_q    <= limit_d;
      low_seen_q <= low_seen_d;
    end
  end
`else
  assign start_ok  = run_req_in;
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_count_out;
    timeout_d = drain_timeout_out;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_ARM;
          cnt_d     = SETTLE_LOAD;
          pkt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_ARM: begin
        if (!run_req_in)        state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_RUN;
        else                    cnt_d   = cnt_q - CNT_ONE;
      end
      S_RUN: begin
        if (beat_last_in) pkt_d = pkt_inc;
        if (!run_req_in || (beat_last_in && limit_hit)) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (beat_last_in) pkt_d = pkt_inc;
        // A packet boundary wins over a coinciding timeout expiry.
        if (beat_last_in || pkt_idle_in) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = S_FLUSH;
          cnt_d     = FLUSH_LOAD;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops are fed from the next state so they stay aligned with state_q.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_in) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      pkt_count_out     <= '0;
      drain_timeout_out <= 1'b0;
      dp_enable_out     <= 1'b0;
      dp_flush_out      <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      pkt_count_out     <= pkt_d;
      drain_timeout_out <= timeout_d;
      dp_enable_out     <= (state_d == S_RUN);
      dp_flush_out      <= (state_d == S_FLUSH);
      busy_out          <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_adc_stream_run_ctrl.sv
// Testbench for adc_stream_run_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the run/stop rules.
module tb_adc_stream_run_ctrl;

  localparam int SETTLE = 4;
  localparam int DRAIN  = 20;
  localparam int FLUSH  = 3;
  localparam int W      = 3;
  localparam int SAT    = (1 << W) - 1;
`ifdef PKT_LIMIT_EN
  localparam bit LIMIT_BUILD = 1'b1;
`else
  localparam bit LIMIT_BUILD = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_in, run_req_in, beat_last_in, pkt_idle_in;
  logic         dp_enable_out, dp_flush_out, busy_out, drain_timeout_out;
  logic [W-1:0] pkt_count_out;
  logic [2:0]   state_out;
`ifdef PKT_LIMIT_EN
  logic [W-1:0] pkt_limit_in;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int limit_val = 0;

  // Behavioural model: phase 0..4 as the externally visible state code, elapsed counts up.
  int m_state = 0, m_elapsed = 0, m_count = 0, m_timeout = 0, m_limit = 0, m_low_seen = 0;

  always #5 clk_in = ~clk_in;

  adc_stream_run_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .DRAIN_TIMEOUT(DRAIN),
    .FLUSH_CYCLES (FLUSH),
    .PKT_CNT_W    (W)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .run_req_in       (run_req_in),
    .beat_last_in     (beat_last_in),
    .pkt_idle_in      (pkt_idle_in),
`ifdef PKT_LIMIT_EN
    .pkt_limit_in     (pkt_limit_in),
`endif
    .dp_enable_out    (dp_enable_out),
    .dp_flush_out     (dp_flush_out),
    .busy_out         (busy_out),
    .pkt_count_out    (pkt_count_out),
    .drain_timeout_out(drain_timeout_out),
    .state_out        (state_out)
  );

  function automatic int sat_inc(input int c);
    return (c >= SAT) ? SAT : c + 1;
  endfunction

  task automatic model_step(input logic r, input logic b, input logic idle, input logic rst,
                            input int lim);
    int prev;
    if (rst) begin
      m_state = 0; m_elapsed = 0; m_count = 0; m_timeout = 0; m_limit = 0; m_low_seen = 0;
      return;
    end
    prev = m_state;
    case (m_state)
      0: if (r && (!LIMIT_BUILD || m_low_seen != 0)) begin
           m_state = 1; m_count = 0; m_timeout = 0; m_limit = lim; m_low_seen = 0;
         end
      1: begin
           m_elapsed++;
           if (!r) m_state = 0;
           else if (m_elapsed == SETTLE) m_state = 2;
         end
      2: begin
           if (b) m_count = sat_inc(m_count);
           if (!r) m_state = 3;
           if (LIMIT_BUILD && b && m_limit != 0 && m_count == m_limit) m_state = 3;
         end
      3: begin
           m_elapsed++;
           if (b) m_count = sat_inc(m_count);
           if (b || idle) m_state = 4;
           else if (m_elapsed == DRAIN) begin m_timeout = 1; m_state = 4; end
         end
      default: begin
           m_elapsed++;
           if (m_elapsed == FLUSH) m_state = 0;
         end
    endcase
    if (!r) m_low_seen = 1;
    if (m_state != prev) m_elapsed = 0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return at the falling edge.
  task automatic tick(input logic r, input logic b, input logic idle, input logic rst);
    run_req_in   = r;
    beat_last_in = b;
    pkt_idle_in  = idle;
    rst_in       = rst;
`ifdef PKT_LIMIT_EN
    pkt_limit_in = W'(limit_val);
`endif
    @(posedge clk_in);
    model_step(r, b, idle, rst, limit_val);
    @(negedge clk_in);
  endtask

  task automatic go_idle();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && state_out !== 3'd0; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (state_out !== 3'd0) begin
      n_fail++; $display("FAIL go_idle_bound: state=%0d expected=0", state_out);
    end
  endtask

  task automatic start_run();
    for (int i = 0; i <= SETTLE; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd2) begin
      n_fail++; $display("FAIL start_run: state=%0d expected=2", state_out);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if ({state_out, dp_enable_out, dp_flush_out, busy_out, pkt_count_out, drain_timeout_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d en=%b fl=%b busy=%b cnt=%0d to=%b expected all 0",
               state_out, dp_enable_out, dp_flush_out, busy_out, pkt_count_out, drain_timeout_out);
    end
  endtask

  task automatic test_start();
    go_idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd1 || busy_out !== 1'b1 || dp_enable_out !== 1'b0) begin
      n_fail++; $display("FAIL start_arm_entry: state=%0d busy=%b en=%b expected 1/1/0",
                         state_out, busy_out, dp_enable_out);
    end
    for (int i = 1; i < SETTLE; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (state_out !== 3'd1 || dp_enable_out !== 1'b0) begin
        n_fail++; $display("FAIL start_arm_hold%0d: state=%0d en=%b expected 1/0", i, state_out, dp_enable_out);
      end
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd2 || dp_enable_out !== 1'b1) begin
      n_fail++; $display("FAIL start_enable: state=%0d en=%b expected 2/1", state_out, dp_enable_out);
    end
  endtask

  task automatic test_count_stop();
    int drain_n, flush_n;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (pkt_count_out !== W'(5)) begin
      n_fail++; $display("FAIL count_five: count=%0d expected=5", pkt_count_out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (state_out !== 3'd3 || dp_enable_out !== 1'b0) begin
      n_fail++; $display("FAIL stop_drain: state=%0d en=%b expected 3/0", state_out, dp_enable_out);
    end
    drain_n = 1;
    flush_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      if (state_out === 3'd3) drain_n++;
      if (dp_flush_out === 1'b1) flush_n++;
    end
    n_tests++;
    if (drain_n != 1 || flush_n != FLUSH) begin
      n_fail++; $display("FAIL stop_lengths: drain=%0d flush=%0d expected 1/%0d", drain_n, flush_n, FLUSH);
    end
    n_tests++;
    if (state_out !== 3'd0 || pkt_count_out !== W'(5)) begin
      n_fail++; $display("FAIL stop_idle_hold: state=%0d count=%0d expected 0/5", state_out, pkt_count_out);
    end
  endtask

  task automatic test_drain_timeout();
    int drain_n;
    go_idle();
    start_run();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    drain_n = 1;
    for (int i = 0; i < 2 * DRAIN && state_out === 3'd3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (state_out === 3'd3) drain_n++;
    end
    n_tests++;
    if (drain_n != DRAIN || state_out !== 3'd4 || drain_timeout_out !== 1'b1) begin
      n_fail++; $display("FAIL drain_timeout: drain=%0d state=%0d to=%b expected %0d/4/1",
                         drain_n, state_out, drain_timeout_out, DRAIN);
    end
    for (int i = 0; i < FLUSH + 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd0 || drain_timeout_out !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: state=%0d to=%b expected 0/1", state_out, drain_timeout_out);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd1 || drain_timeout_out !== 1'b0 || pkt_count_out !== '0) begin
      n_fail++; $display("FAIL timeout_clear: state=%0d to=%b count=%0d expected 1/0/0",
                         state_out, drain_timeout_out, pkt_count_out);
    end
    // Boundary arriving on the very last drain cycle is a normal exit.
    go_idle();
    start_run();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < DRAIN; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (state_out !== 3'd4 || drain_timeout_out !== 1'b0) begin
      n_fail++; $display("FAIL drain_coincide: state=%0d to=%b expected 4/0", state_out, drain_timeout_out);
    end
  endtask

  task automatic test_abort_arm();
    bit seen;
    go_idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    seen = (dp_enable_out === 1'b1) || (dp_flush_out === 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd0) begin
      n_fail++; $display("FAIL abort_idle: state=%0d expected=0", state_out);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (dp_enable_out === 1'b1 || dp_flush_out === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL abort_no_pulse: en_or_flush_seen=%b expected=0", seen);
    end
  endtask

  task automatic test_rearm();
    go_idle();
    start_run();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd3) begin
      n_fail++; $display("FAIL rearm_drain_ignores_req: state=%0d expected=3", state_out);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < FLUSH; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd4) begin
      n_fail++; $display("FAIL rearm_flush_ignores_req: state=%0d expected=4", state_out);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd0) begin
      n_fail++; $display("FAIL rearm_idle: state=%0d expected=0", state_out);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd1) begin
      n_fail++; $display("FAIL rearm_arm: state=%0d expected=1", state_out);
    end
  endtask

  task automatic test_reset_mid_run();
    bit fl_seen;
    go_idle();
    start_run();
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if ({state_out, dp_enable_out, dp_flush_out, busy_out, pkt_count_out, drain_timeout_out} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: state=%0d en=%b busy=%b cnt=%0d expected all 0",
                         state_out, dp_enable_out, busy_out, pkt_count_out);
    end
    fl_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (dp_flush_out === 1'b1) fl_seen = 1'b1;
    end
    n_tests++;
    if (fl_seen) begin
      n_fail++; $display("FAIL reset_no_flush: flush_seen=%b expected=0", fl_seen);
    end
  endtask

  task automatic test_saturation();
    go_idle();
    limit_val = 0;
    start_run();
    for (int i = 0; i < SAT + 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (pkt_count_out !== W'(SAT) || state_out !== 3'd2) begin
      n_fail++; $display("FAIL count_saturate: count=%0d state=%0d expected %0d/2", pkt_count_out, state_out, SAT);
    end
  endtask

`ifdef PKT_LIMIT_EN
  task automatic test_pkt_limit();
    go_idle();
    limit_val = 3;
    start_run();
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd2 || pkt_count_out !== W'(2)) begin
      n_fail++; $display("FAIL limit_before: state=%0d count=%0d expected 2/2", state_out, pkt_count_out);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (state_out !== 3'd3 || pkt_count_out !== W'(3)) begin
      n_fail++; $display("FAIL limit_autostop: state=%0d count=%0d expected 3/3", state_out, pkt_count_out);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (state_out !== 3'd0 || pkt_count_out !== W'(3)) begin
      n_fail++; $display("FAIL limit_no_rearm: state=%0d count=%0d expected 0/3", state_out, pkt_count_out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (state_out !== 3'd1) begin
      n_fail++; $display("FAIL limit_edge_rearm: state=%0d expected=1", state_out);
    end
    limit_val = 0;
  endtask
`endif

  task automatic test_random();
    logic        r, b, idle, rst;
    bit          quiet;
    logic [W+6:0] got_v, exp_v;
    go_idle();
    r = 1'b0;
    quiet = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) == 0) quiet = ~quiet;
      if ($urandom_range(0, 11) == 0) r = ~r;
      b    = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      idle = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      if (LIMIT_BUILD && $urandom_range(0, 199) == 0) limit_val = int'($urandom_range(0, 4));
      tick(r, b, idle, rst);
      got_v = {state_out, dp_enable_out, dp_flush_out, busy_out, pkt_count_out, drain_timeout_out};
      exp_v = {3'(m_state), m_state == 2, m_state == 4, m_state != 0, W'(m_count), m_timeout != 0};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got state=%0d en=%b fl=%b busy=%b cnt=%0d to=%b expected state=%0d cnt=%0d to=%0d",
                 cyc, state_out, dp_enable_out, dp_flush_out, busy_out, pkt_count_out, drain_timeout_out,
                 m_state, m_count, m_timeout);
        break;
      end
    end
    limit_val = 0;
  endtask

  initial begin
    rst_in = 1'b1; run_req_in = 1'b0; beat_last_in = 1'b0; pkt_idle_in = 1'b0;
`ifdef PKT_LIMIT_EN
    pkt_limit_in = '0;
`endif
    test_reset();
    test_start();
    test_count_stop();
    test_drain_timeout();
    test_abort_arm();
    test_rearm();
    test_reset_mid_run();
    test_saturation();
`ifdef PKT_LIMIT_EN
    test_pkt_limit();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
